// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, bubble bundle, FSM type and memory-op helpers
package core_pkg;

    localparam logic [5:0]  OP_LD    = 6'b010000;
    localparam logic [5:0]  OP_ST    = 6'b010001;
    localparam logic [63:0] NOP_INST = 64'h0;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } fsm_t;

    function automatic logic is_mem(input logic [5:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // Byte enables for one 32-bit lane of a 64-bit row.
    function automatic logic [7:0] lane_web(input logic lane);
        return lane ? 8'hF0 : 8'h0F;
    endfunction

endpackage

// File: rtl/lane_steer.sv
// rtl/lane_steer.sv - selects each slot's load word from BRAM data or the hold register
module lane_steer (
    input  logic [63:0] rdata,
    input  logic        u_lane,
    input  logic        l_lane,
    input  logic        u_from_hold,
    input  logic        l_from_hold,
    input  logic [31:0] hold,
    output logic [63:0] dout
);

    logic [31:0] u_word;
    logic [31:0] l_word;

    always_comb begin
        u_word = u_lane ? rdata[63:32] : rdata[31:0];
        l_word = l_lane ? rdata[63:32] : rdata[31:0];
        dout   = {(u_from_hold ? hold : u_word), (l_from_hold ? hold : l_word)};
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - dual-slot memory-access stage driving BRAM port B, splits cross-row pairs
module mem_access #(
    parameter int          ADDR_W   = 16,
    parameter logic [63:0] NOP_INST = 64'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interlock,
    input  logic [63:0]       inst_from_exec,
    input  logic [31:0]       u_tdata_from_exec,
    input  logic [31:0]       l_tdata_from_exec,
    input  logic [31:0]       u_sdata_from_exec,
    input  logic [31:0]       l_sdata_from_exec,
    input  logic [4:0]        u_rt_from_exec,
    input  logic [4:0]        l_rt_from_exec,
    input  logic              u_rt_flag_from_exec,
    input  logic              l_rt_flag_from_exec,
    output logic [63:0]       inst_to_wb,
    output logic [4:0]        u_rt_to_wb,
    output logic [4:0]        l_rt_to_wb,
    output logic              u_rt_flag_to_wb,
    output logic              l_rt_flag_to_wb,
    output logic [31:0]       l_tdata_to_wb,
    output logic [63:0]       mem_doutb,
    output logic [ADDR_W-1:0] bram_addrb,
    output logic              bram_enb,
    output logic [7:0]        bram_web,
    output logic [63:0]       bram_dinb,
    input  logic [63:0]       bram_doutb,
    output logic              mem_stall
);
    import core_pkg::*;

    fsm_t        state;
    logic [31:0] hold;
    logic        u_lane_r;
    logic        l_lane_r;
    logic        u_from_hold_r;
    logic        l_from_hold_r;

    logic [5:0]        u_op;
    logic [5:0]        l_op;
    logic              u_ld;
    logic              u_st;
    logic              l_ld;
    logic              l_st;
    logic              u_mem;
    logic              l_mem;
    logic              u_lane;
    logic              l_lane;
    logic [ADDR_W-1:0] u_row;
    logic [ADDR_W-1:0] l_row;
    logic              split;
    logic              fwd;
    logic              unused_addr_bits;

    assign u_op   = inst_from_exec[63:58];
    assign l_op   = inst_from_exec[31:26];
    assign u_ld   = (u_op == OP_LD);
    assign u_st   = (u_op == OP_ST);
    assign l_ld   = (l_op == OP_LD);
    assign l_st   = (l_op == OP_ST);
    assign u_mem  = is_mem(u_op);
    assign l_mem  = is_mem(l_op);
    assign u_lane = u_tdata_from_exec[0];
    assign l_lane = l_tdata_from_exec[0];
    assign u_row  = u_tdata_from_exec[ADDR_W:1];
    assign l_row  = l_tdata_from_exec[ADDR_W:1];
    assign split  = u_mem && l_mem && (u_row != l_row);
    // Read-first BRAM returns the pre-store word, so an upper store feeding a lower load is bypassed.
    assign fwd    = u_st && l_ld && (u_row == l_row) && (u_lane == l_lane);

    assign unused_addr_bits = ^u_tdata_from_exec[31:ADDR_W+1];

    always_comb begin
        bram_enb   = 1'b0;
        bram_addrb = u_row;
        bram_web   = 8'h00;
        bram_dinb  = {u_sdata_from_exec, u_sdata_from_exec};
        mem_stall  = 1'b0;
        if (!rst && !interlock) begin
            if (state == SECOND) begin
                bram_enb   = 1'b1;
                bram_addrb = l_row;
                bram_web   = l_st ? lane_web(l_lane) : 8'h00;
                bram_dinb  = {l_sdata_from_exec, l_sdata_from_exec};
            end else if (split) begin
                mem_stall = 1'b1;
                bram_enb  = 1'b1;
                bram_web  = u_st ? lane_web(u_lane) : 8'h00;
            end else begin
                bram_enb   = u_mem || l_mem;
                bram_addrb = u_mem ? u_row : l_row;
                bram_web   = (u_st ? lane_web(u_lane) : 8'h00) |
                             (l_st ? lane_web(l_lane) : 8'h00);
                // Lower store owns its lane so it wins a same-word collision.
                bram_dinb[63:32] = (l_st && l_lane)  ? l_sdata_from_exec : u_sdata_from_exec;
                bram_dinb[31:0]  = (l_st && !l_lane) ? l_sdata_from_exec : u_sdata_from_exec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            inst_to_wb      <= NOP_INST;
            u_rt_to_wb      <= 5'd0;
            l_rt_to_wb      <= 5'd0;
            u_rt_flag_to_wb <= 1'b0;
            l_rt_flag_to_wb <= 1'b0;
            l_tdata_to_wb   <= 32'd0;
            hold            <= 32'd0;
            u_lane_r        <= 1'b0;
            l_lane_r        <= 1'b0;
            u_from_hold_r   <= 1'b0;
            l_from_hold_r   <= 1'b0;
        end else if (!interlock) begin
            if (state == IDLE && split) begin
                state           <= SECOND;
                inst_to_wb      <= NOP_INST;
                u_rt_to_wb      <= 5'd0;
                l_rt_to_wb      <= 5'd0;
                u_rt_flag_to_wb <= 1'b0;
                l_rt_flag_to_wb <= 1'b0;
                l_tdata_to_wb   <= 32'd0;
            end else begin
                state           <= IDLE;
                inst_to_wb      <= inst_from_exec;
                u_rt_to_wb      <= u_rt_from_exec;
                l_rt_to_wb      <= l_rt_from_exec;
                u_rt_flag_to_wb <= u_rt_flag_from_exec;
                l_rt_flag_to_wb <= l_rt_flag_from_exec;
                l_tdata_to_wb   <= l_tdata_from_exec;
                u_lane_r        <= u_lane;
                l_lane_r        <= l_lane;
                if (state == SECOND) begin
                    hold          <= u_lane ? bram_doutb[63:32] : bram_doutb[31:0];
                    u_from_hold_r <= 1'b1;
                    l_from_hold_r <= 1'b0;
                end else begin
                    if (fwd) begin
                        hold <= u_sdata_from_exec;
                    end
                    u_from_hold_r <= 1'b0;
                    l_from_hold_r <= fwd;
                end
            end
        end
    end

    lane_steer u_lane_steer (
        .rdata       (bram_doutb),
        .u_lane      (u_lane_r),
        .l_lane      (l_lane_r),
        .u_from_hold (u_from_hold_r),
        .l_from_hold (l_from_hold_r),
        .hold        (hold),
        .dout        (mem_doutb)
    );

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access with a program-order memory model
module tb_mem_access;
    import core_pkg::*;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              interlock;
    logic [63:0]       inst_from_exec;
    logic [31:0]       u_tdata_from_exec, l_tdata_from_exec;
    logic [31:0]       u_sdata_from_exec, l_sdata_from_exec;
    logic [4:0]        u_rt_from_exec, l_rt_from_exec;
    logic              u_rt_flag_from_exec, l_rt_flag_from_exec;
    logic [63:0]       inst_to_wb;
    logic [4:0]        u_rt_to_wb, l_rt_to_wb;
    logic              u_rt_flag_to_wb, l_rt_flag_to_wb;
    logic [31:0]       l_tdata_to_wb;
    logic [63:0]       mem_doutb;
    logic [ADDR_W-1:0] bram_addrb;
    logic              bram_enb;
    logic [7:0]        bram_web;
    logic [63:0]       bram_dinb;
    logic [63:0]       bram_doutb;
    logic              mem_stall;

    int errors = 0;
    int checks = 0;

    // External BRAM: 64-bit rows, byte enables, read-first, 1-cycle latency.
    logic [63:0] bram [0:255];
    logic [63:0] bram_q = 64'h0;
    logic [63:0] wrow;
    assign bram_doutb = bram_q;
    always @(posedge clk) begin
        if (bram_enb) begin
            wrow = bram[bram_addrb[7:0]];
            bram_q <= wrow;
            for (int i = 0; i < 8; i++)
                if (bram_web[i]) wrow[8*i +: 8] = bram_dinb[8*i +: 8];
            bram[bram_addrb[7:0]] <= wrow;
        end
    end

    // Reference: word-addressed memory updated in program order (upper slot, then lower slot).
    logic [31:0] ref_mem [0:511];

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(ADDR_W), .NOP_INST(64'h0)) dut (
        .clk(clk), .rst(rst), .interlock(interlock),
        .inst_from_exec(inst_from_exec),
        .u_tdata_from_exec(u_tdata_from_exec), .l_tdata_from_exec(l_tdata_from_exec),
        .u_sdata_from_exec(u_sdata_from_exec), .l_sdata_from_exec(l_sdata_from_exec),
        .u_rt_from_exec(u_rt_from_exec), .l_rt_from_exec(l_rt_from_exec),
        .u_rt_flag_from_exec(u_rt_flag_from_exec), .l_rt_flag_from_exec(l_rt_flag_from_exec),
        .inst_to_wb(inst_to_wb), .u_rt_to_wb(u_rt_to_wb), .l_rt_to_wb(l_rt_to_wb),
        .u_rt_flag_to_wb(u_rt_flag_to_wb), .l_rt_flag_to_wb(l_rt_flag_to_wb),
        .l_tdata_to_wb(l_tdata_to_wb), .mem_doutb(mem_doutb),
        .bram_addrb(bram_addrb), .bram_enb(bram_enb), .bram_web(bram_web),
        .bram_dinb(bram_dinb), .bram_doutb(bram_doutb), .mem_stall(mem_stall)
    );

    function automatic logic [7:0] mask_of(input logic lane);
        return lane ? 8'hF0 : 8'h0F;
    endfunction

    function automatic logic [5:0] rand_op();
        int r;
        logic [5:0] op;
        r = $urandom_range(0, 3);
        if (r == 0) return OP_LD;
        if (r == 1) return OP_ST;
        op = 6'($urandom);
        if (op == OP_LD || op == OP_ST) op = 6'h00;
        return op;
    endfunction

    task automatic poke(input int w, input logic [31:0] v);
        ref_mem[w] = v;
        if (w % 2 == 1) bram[w / 2][63:32] = v;
        else            bram[w / 2][31:0]  = v;
    endtask

    task automatic drive_idle();
        inst_from_exec      = 64'h0;
        u_tdata_from_exec   = 32'h0;
        l_tdata_from_exec   = 32'h0;
        u_sdata_from_exec   = 32'h0;
        l_sdata_from_exec   = 32'h0;
        u_rt_from_exec      = 5'd0;
        l_rt_from_exec      = 5'd0;
        u_rt_flag_from_exec = 1'b0;
        l_rt_flag_from_exec = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where the bundle's results are checked.
    task automatic run_bundle(input logic [5:0] uo, input logic [5:0] lo,
                              input logic [31:0] ut, input logic [31:0] lt,
                              input logic [31:0] us, input logic [31:0] ls);
        logic [63:0] inst;
        logic [4:0]  urt, lrt;
        logic        uf, lf, um, lm, sp, ee;
        logic [31:0] eu, el;
        logic [7:0]  ew;
        logic [15:0] ea;
        inst = {uo, 26'($urandom), lo, 26'($urandom)};
        urt = 5'($urandom); lrt = 5'($urandom);
        uf = 1'($urandom);  lf = 1'($urandom);
        um = (uo == OP_LD) || (uo == OP_ST);
        lm = (lo == OP_LD) || (lo == OP_ST);
        sp = um && lm && (ut[16:1] != lt[16:1]);
        eu = 32'h0; el = 32'h0;
        if (uo == OP_LD) eu = ref_mem[ut[8:0]];
        if (uo == OP_ST) ref_mem[ut[8:0]] = us;
        if (lo == OP_LD) el = ref_mem[lt[8:0]];
        if (lo == OP_ST) ref_mem[lt[8:0]] = ls;
        if (sp) begin
            ee = 1'b1; ea = ut[16:1];
            ew = (uo == OP_ST) ? mask_of(ut[0]) : 8'h00;
        end else begin
            ee = um || lm; ea = um ? ut[16:1] : lt[16:1];
            ew = ((uo == OP_ST) ? mask_of(ut[0]) : 8'h00) | ((lo == OP_ST) ? mask_of(lt[0]) : 8'h00);
        end

        inst_from_exec = inst;
        u_tdata_from_exec = ut; l_tdata_from_exec = lt;
        u_sdata_from_exec = us; l_sdata_from_exec = ls;
        u_rt_from_exec = urt;   l_rt_from_exec = lrt;
        u_rt_flag_from_exec = uf; l_rt_flag_from_exec = lf;
        #1;
        checks++;
        if (mem_stall !== sp) begin errors++; $display("FAIL stall: got %b expected %b", mem_stall, sp); end
        checks++;
        if (bram_enb !== ee) begin errors++; $display("FAIL enb: got %b expected %b", bram_enb, ee); end
        if (ee) begin
            checks++;
            if (bram_addrb !== ea || bram_web !== ew) begin
                errors++; $display("FAIL access1: got addr %h web %h expected addr %h web %h", bram_addrb, bram_web, ea, ew);
            end
        end
        @(posedge clk);
        if (sp) begin
            @(negedge clk);
            checks++;
            if (inst_to_wb !== 64'h0 || u_rt_flag_to_wb !== 1'b0 || l_rt_flag_to_wb !== 1'b0) begin
                errors++; $display("FAIL bubble: got inst %h flags %b%b expected 0 00", inst_to_wb, u_rt_flag_to_wb, l_rt_flag_to_wb);
            end
            ew = (lo == OP_ST) ? mask_of(lt[0]) : 8'h00;
            checks++;
            if (mem_stall !== 1'b0 || bram_enb !== 1'b1 || bram_addrb !== lt[16:1] || bram_web !== ew) begin
                errors++; $display("FAIL access2: got stall %b enb %b addr %h web %h expected 0 1 %h %h",
                                   mem_stall, bram_enb, bram_addrb, bram_web, lt[16:1], ew);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (inst_to_wb !== inst || u_rt_to_wb !== urt || l_rt_to_wb !== lrt ||
            u_rt_flag_to_wb !== uf || l_rt_flag_to_wb !== lf || l_tdata_to_wb !== lt) begin
            errors++; $display("FAIL wb_regs: got %h %h %h %b %b %h expected %h %h %h %b %b %h",
                               inst_to_wb, u_rt_to_wb, l_rt_to_wb, u_rt_flag_to_wb, l_rt_flag_to_wb, l_tdata_to_wb,
                               inst, urt, lrt, uf, lf, lt);
        end
        if (uo == OP_LD) begin
            checks++;
            if (mem_doutb[63:32] !== eu) begin errors++; $display("FAIL u_load: got %h expected %h", mem_doutb[63:32], eu); end
        end
        if (lo == OP_LD) begin
            checks++;
            if (mem_doutb[31:0] !== el) begin errors++; $display("FAIL l_load: got %h expected %h", mem_doutb[31:0], el); end
        end
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1; interlock = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (inst_to_wb !== 64'h0 || u_rt_flag_to_wb !== 1'b0 || l_rt_flag_to_wb !== 1'b0 ||
            u_rt_to_wb !== 5'd0 || l_rt_to_wb !== 5'd0 || l_tdata_to_wb !== 32'h0) begin
            errors++; $display("FAIL reset_regs: got %h %b %b %h %h %h expected all zero",
                               inst_to_wb, u_rt_flag_to_wb, l_rt_flag_to_wb, u_rt_to_wb, l_rt_to_wb, l_tdata_to_wb);
        end
        checks++;
        if (mem_stall !== 1'b0 || bram_enb !== 1'b0 || bram_web !== 8'h00) begin
            errors++; $display("FAIL reset_bram: got stall %b enb %b web %h expected 0 0 00", mem_stall, bram_enb, bram_web);
        end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        run_bundle(OP_ST, 6'h00, 32'd5, 32'h1234_5678, 32'hDEAD, 32'h0);
        run_bundle(OP_LD, 6'h00, 32'd5, 32'h0000_0042, 32'h0, 32'h0);
    endtask

    task automatic test_forward();
        run_bundle(OP_ST, OP_LD, 32'd4, 32'd4, 32'h1234, 32'h0);
        run_bundle(OP_LD, OP_ST, 32'd4, 32'd4, 32'h0, 32'h5555);
        run_bundle(OP_LD, 6'h00, 32'd4, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_split_load();
        poke(2, 32'hAA);
        poke(9, 32'hBB);
        run_bundle(OP_LD, OP_LD, 32'd2, 32'd9, 32'h0, 32'h0);
        checks++;
        if (mem_doutb !== 64'h000000AA_000000BB) begin
            errors++; $display("FAIL split_dout: got %h expected %h", mem_doutb, 64'h000000AA_000000BB);
        end
    endtask

    task automatic test_st_st();
        run_bundle(OP_ST, OP_ST, 32'd6, 32'd6, 32'd1, 32'd2);
        run_bundle(OP_LD, 6'h00, 32'd6, 32'h0, 32'h0, 32'h0);
        run_bundle(OP_ST, OP_ST, 32'd10, 32'd11, 32'd3, 32'd4);
        run_bundle(OP_LD, OP_LD, 32'd11, 32'd10, 32'h0, 32'h0);
    endtask

    task automatic test_interlock();
        poke(20, 32'hC0DE_0001);
        poke(33, 32'hC0DE_0002);
        inst_from_exec = {OP_LD, 26'h1, OP_LD, 26'h2};
        u_tdata_from_exec = 32'd20; l_tdata_from_exec = 32'd33;
        u_rt_from_exec = 5'd7; l_rt_from_exec = 5'd9;
        u_rt_flag_from_exec = 1'b1; l_rt_flag_from_exec = 1'b1;
        #1;
        checks++;
        if (mem_stall !== 1'b1) begin errors++; $display("FAIL il_stall: got %b expected 1", mem_stall); end
        @(posedge clk);
        @(negedge clk);
        interlock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bram_enb !== 1'b0 || mem_stall !== 1'b0 || inst_to_wb !== 64'h0) begin
                errors++; $display("FAIL il_freeze: got enb %b stall %b inst %h expected 0 0 0", bram_enb, mem_stall, inst_to_wb);
            end
            @(posedge clk);
            @(negedge clk);
        end
        interlock = 1'b0;
        #1;
        checks++;
        if (bram_enb !== 1'b1 || bram_addrb !== 16'd16) begin
            errors++; $display("FAIL il_second: got enb %b addr %h expected 1 0010", bram_enb, bram_addrb);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_doutb !== 64'hC0DE0001_C0DE0002 || inst_to_wb !== {OP_LD, 26'h1, OP_LD, 26'h2} || u_rt_to_wb !== 5'd7) begin
            errors++; $display("FAIL il_result: got %h inst %h rt %h expected %h", mem_doutb, inst_to_wb, u_rt_to_wb, 64'hC0DE0001_C0DE0002);
        end
        // Freeze in IDLE: new load presented, nothing moves and prior load data stays visible.
        inst_from_exec = {OP_LD, 26'h3, 32'h0};
        u_tdata_from_exec = 32'd33;
        interlock = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_doutb !== 64'hC0DE0001_C0DE0002 || inst_to_wb !== {OP_LD, 26'h1, OP_LD, 26'h2} || bram_enb !== 1'b0) begin
            errors++; $display("FAIL il_idle: got %h inst %h enb %b expected %h", mem_doutb, inst_to_wb, bram_enb, 64'hC0DE0001_C0DE0002);
        end
        interlock = 1'b0;
        drive_idle();
    endtask

    task automatic test_reset_mid_split();
        inst_from_exec = {OP_LD, 26'h5, OP_LD, 26'h6};
        u_tdata_from_exec = 32'd2; l_tdata_from_exec = 32'd9;
        u_rt_flag_from_exec = 1'b1; l_rt_flag_from_exec = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bram_enb !== 1'b0 || mem_stall !== 1'b0) begin
            errors++; $display("FAIL rst_second: got enb %b stall %b expected 0 0", bram_enb, mem_stall);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (inst_to_wb !== 64'h0 || u_rt_flag_to_wb !== 1'b0 || mem_stall !== 1'b1) begin
            errors++; $display("FAIL rst_abandon: got inst %h flag %b stall %b expected 0 0 1", inst_to_wb, u_rt_flag_to_wb, mem_stall);
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_random_back_to_back();
        logic [5:0]  uo, lo;
        logic [31:0] ut, lt;
        for (int n = 0; n < 250; n++) begin
            uo = rand_op();
            lo = rand_op();
            ut = (uo == OP_LD || uo == OP_ST) ? ((n % 3 == 0) ? 32'($urandom_range(0, 511)) : 32'($urandom_range(0, 15))) : $urandom;
            lt = (lo == OP_LD || lo == OP_ST) ? ((n % 3 == 0) ? 32'($urandom_range(0, 511)) : 32'($urandom_range(0, 15))) : $urandom;
            run_bundle(uo, lo, ut, lt, $urandom, $urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bram[i] = 64'h0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_store_load();
        test_forward();
        test_split_load();
        test_st_st();
        test_interlock();
        test_reset_mid_split();
        test_random_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
